// File: rtl/calc_axil_slave.sv
// AXI4-Lite register slave wrapping a small iterative calculator:
// add/sub in one cycle, 32-step shift-add multiply and restoring divide.
module calc_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    output logic                              calc_done
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t state, state_next;

    logic [31:0] opa, opb, lat_a, lat_b, work_hi, work_lo, res_lo, res_hi, rd_mux;
    logic [1:0]  op, lat_op, start_op;
    logic [4:0]  iter;
    logic        done_flag, div0_flag, busy, wr_fire, wr_err, start_go, single_cycle, run_last;
    logic [2:0]  wr_sel, rd_sel;
    logic [32:0] mul_sum, div_shift, div_diff;
    logic [31:0] mul_hi, mul_lo, div_hi, div_lo;
    logic        div_ok;
    logic        unused_ok;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] data,
                                                input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (strb[i]) r[i*8 +: 8] = data[i*8 +: 8];
        return r;
    endfunction

    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};
    assign wr_sel    = s00_axi_awaddr[4:2];
    assign rd_sel    = s00_axi_araddr[4:2];
    assign busy      = (state != IDLE);
    assign wr_fire   = s00_axi_awready && s00_axi_awvalid && s00_axi_wready && s00_axi_wvalid;
    assign wr_err    = busy && (wr_sel <= 3'd2);
    assign start_go  = wr_fire && !busy && (wr_sel == 3'd2) && s00_axi_wstrb[1] && s00_axi_wdata[8];
    assign start_op  = s00_axi_wstrb[0] ? s00_axi_wdata[1:0] : op;
    assign s00_axi_wready = s00_axi_awready;

    // One multiply step: conditionally add A into the upper half, then shift the product right.
    assign mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, lat_a} : 33'd0);
    assign mul_hi    = mul_sum[32:1];
    assign mul_lo    = {mul_sum[0], work_lo[31:1]};
    // One restoring divide step: remainder in work_hi, dividend/quotient shifting through work_lo.
    assign div_shift = {work_hi, work_lo[31]};
    assign div_diff  = div_shift - {1'b0, lat_b};
    assign div_ok    = !div_diff[32];
    assign div_hi    = div_ok ? div_diff[31:0] : div_shift[31:0];
    assign div_lo    = {work_lo[30:0], div_ok};

    assign single_cycle = !lat_op[1] || ((lat_op == 2'd3) && (lat_b == 32'd0));
    assign run_last     = single_cycle || (iter == 5'd31);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_go) state_next = RUN;
            RUN:     if (run_last) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) state <= IDLE;
        else                state <= state_next;
    end

    always_comb begin
        rd_mux = 32'd0;
        case (rd_sel)
            3'd0:    rd_mux = opa;
            3'd1:    rd_mux = opb;
            3'd2:    rd_mux = {30'd0, op};
            3'd3:    rd_mux = {29'd0, div0_flag, done_flag, busy};
            3'd4:    rd_mux = res_lo;
            3'd5:    rd_mux = res_hi;
            default: rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            s00_axi_awready <= 1'b0;
            s00_axi_bvalid  <= 1'b0;
            s00_axi_bresp   <= 2'b00;
            s00_axi_arready <= 1'b0;
            s00_axi_rvalid  <= 1'b0;
            s00_axi_rresp   <= 2'b00;
            s00_axi_rdata   <= 32'd0;
        end else begin
            s00_axi_awready <= !s00_axi_awready && s00_axi_awvalid && s00_axi_wvalid && !s00_axi_bvalid;
            if (wr_fire) begin
                s00_axi_bvalid <= 1'b1;
                s00_axi_bresp  <= wr_err ? 2'b10 : 2'b00;
            end else if (s00_axi_bready) begin
                s00_axi_bvalid <= 1'b0;
            end
            s00_axi_arready <= !s00_axi_arready && s00_axi_arvalid && !s00_axi_rvalid;
            if (s00_axi_arready && s00_axi_arvalid) begin
                s00_axi_rvalid <= 1'b1;
                s00_axi_rdata  <= rd_mux;
                s00_axi_rresp  <= 2'b00;
            end else if (s00_axi_rready) begin
                s00_axi_rvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            opa <= 32'd0;
            opb <= 32'd0;
            op  <= 2'd0;
        end else if (wr_fire && !busy) begin
            case (wr_sel)
                3'd0:    opa <= merge_bytes(opa, s00_axi_wdata, s00_axi_wstrb);
                3'd1:    opb <= merge_bytes(opb, s00_axi_wdata, s00_axi_wstrb);
                3'd2:    if (s00_axi_wstrb[0]) op <= s00_axi_wdata[1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            lat_a     <= 32'd0;
            lat_b     <= 32'd0;
            lat_op    <= 2'd0;
            work_hi   <= 32'd0;
            work_lo   <= 32'd0;
            iter      <= 5'd0;
            res_lo    <= 32'd0;
            res_hi    <= 32'd0;
            done_flag <= 1'b0;
            div0_flag <= 1'b0;
            calc_done <= 1'b0;
        end else begin
            calc_done <= (state == FIN);
            if (state == FIN) done_flag <= 1'b1;
            if (start_go) begin
                lat_a     <= opa;
                lat_b     <= opb;
                lat_op    <= start_op;
                work_hi   <= 32'd0;
                work_lo   <= (start_op == 2'd2) ? opb : opa;
                iter      <= 5'd0;
                done_flag <= 1'b0;
                div0_flag <= 1'b0;
            end else if (state == RUN) begin
                iter <= iter + 5'd1;
                case (lat_op)
                    2'd0: begin
                        res_lo <= lat_a + lat_b;
                        res_hi <= 32'd0;
                    end
                    2'd1: begin
                        res_lo <= lat_a - lat_b;
                        res_hi <= {31'd0, (lat_a < lat_b)};
                    end
                    2'd2: begin
                        work_hi <= mul_hi;
                        work_lo <= mul_lo;
                        if (run_last) begin
                            res_hi <= mul_hi;
                            res_lo <= mul_lo;
                        end
                    end
                    default: begin
                        if (lat_b == 32'd0) begin
                            res_lo    <= 32'hFFFF_FFFF;
                            res_hi    <= lat_a;
                            div0_flag <= 1'b1;
                        end else begin
                            work_hi <= div_hi;
                            work_lo <= div_lo;
                            if (run_last) begin
                                res_hi <= div_hi;
                                res_lo <= div_lo;
                            end
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/calc_axil_slave.md
CALC_AXIL_SLAVE -- requirements
Module: calc_axil_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI data width; only 32 supported.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 5, AXI byte-address width.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 s00_axi_aclk  in  1  sole clock; all state on rising edge.
REQ-005 s00_axi_areset  in  1  asynchronous, active-high reset.
REQ-006 s00_axi_awaddr/awprot/awvalid/awready  in/in/in/out  5/3/1/1  write address channel; awprot ignored.
REQ-007 s00_axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel.
REQ-008 s00_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response channel.
REQ-009 s00_axi_araddr/arprot/arvalid/arready  in/in/in/out  5/3/1/1  read address channel; arprot ignored.
REQ-010 s00_axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data channel.
REQ-011 calc_done  out  1  one-cycle pulse on operation completion.

Function
REQ-012 Register map (addr[4:2]) SHALL be: 0x00 OPA RW; 0x04 OPB RW; 0x08 CTRL RW: [1:0] OP (00 add, 01 sub, 10 unsigned mul, 11 unsigned div), [8] START write-1, reads 0; 0x0C STATUS RO: [0] BUSY, [1] DONE sticky, [2] DIV0; 0x10 RES_LO RO; 0x14 RES_HI RO.
REQ-013 Write SHALL be accepted only when awvalid and wvalid are both high and bvalid is low: awready and wready high together for exactly one cycle, then bvalid high next cycle and held until bready.
REQ-014 Read SHALL be accepted when arvalid high and rvalid low: arready high one cycle, then rvalid high with rdata next cycle, held stable until rready.
REQ-015 Byte lanes with wstrb=0 SHALL leave the corresponding register bytes unchanged.
REQ-016 Unmapped addresses and RO registers SHALL ignore writes with BRESP OKAY; unmapped reads SHALL return 0 with RRESP OKAY.
REQ-017 Writes to OPA/OPB/CTRL while BUSY=1 SHALL be discarded with BRESP SLVERR (2'b10); START while busy SHALL be ignored.
REQ-018 FSM states SHALL be IDLE, RUN, FIN; IDLE->RUN on accepted START (busy=0), which also clears DONE and DIV0 and latches OPA, OPB, OP.
REQ-019 In RUN, add/sub SHALL complete in 1 cycle, mod 2^32, RES_HI=0 for add, RES_HI=borrow (0/1) for sub.
REQ-020 In RUN, mul SHALL be 32-iteration shift-add, 64-bit product in RES_HI:RES_LO.
REQ-021 In RUN, div SHALL be 32-iteration restoring: quotient to RES_LO, remainder to RES_HI.
REQ-022 Divide by OPB=0 SHALL skip iterations: RES_LO=0xFFFFFFFF, RES_HI=OPA, DIV0=1, 1-cycle RUN.
REQ-023 RUN->FIN when iterations done; FIN->IDLE next cycle, setting DONE=1 and pulsing calc_done for that one cycle.
REQ-024 Latency: START accepted at edge N -> BUSY=1 from N+1; add/sub/div0 DONE visible at N+3; mul/div DONE visible at N+34.
REQ-025 BUSY SHALL be 1 in RUN and FIN, 0 in IDLE; RES_LO/RES_HI SHALL update only on entry to FIN.
REQ-026 Simultaneous write and read SHALL both proceed; a read of STATUS in the completion cycle returns pre-update value.

Reset
REQ-027 On s00_axi_areset=1, all ready/valid outputs SHALL be 0, bresp=rresp=0, rdata=0, calc_done=0.
REQ-028 On reset, all registers SHALL be 0 and the FSM IDLE, including mid-operation; partial results discarded.
REQ-029 After reset deassertion, first transaction SHALL be accepted no earlier than the next rising edge.

Verification
REQ-030 Write OPA=7, OPB=5, CTRL=0x100 (add) -> poll STATUS to 0x2; RES_LO=0x0000000C, RES_HI=0.
REQ-031 OPA=0xFFFFFFFF, OPB=2, CTRL=0x102 (mul) -> DONE after 33 busy cycles; RES_HI=0x00000001, RES_LO=0xFFFFFFFE; calc_done one pulse.
REQ-032 OPA=100, OPB=7, CTRL=0x103 -> RES_LO=14, RES_HI=2; then OPB=0 and START -> RES_LO=0xFFFFFFFF, RES_HI=100, STATUS=0x6.
REQ-033 During mul, write OPA=0x55 -> BRESP=2'b10, OPA read back unchanged; wstrb=4'b0001 write 0xAABBCCDD to idle OPB=0 -> OPB=0x000000DD.
REQ-034 Hold bready/rready low 5 cycles -> bvalid/rvalid and rdata held stable, no new address accepted.
REQ-035 Assert reset 10 cycles into div -> all registers read 0, STATUS=0, calc_done never pulses.
